keypad_scan_ctrl: RTL
=====================

# keypad_scan_ctrl

Sequencing controller for the 4-row × 3-column phone keypad. It rotates the row drive and samples the columns. It debounces both press and release, and latches a 4-bit key code into a holding register. It then raises a one-cycle interrupt and a valid flag that the CPU interrupt service routine clears with an acknowledge. It sits between the keypad pins and the CPU port/interrupt logic, and replaces free-running clock-divided scanning with a single-clock, tick-enabled controller.

## Interface
- SCAN_DIV, default 20000: CLK cycles per scan tick; legal range ≥ 2.
- DEBOUNCE_TICKS, default 3: consecutive identical samples required to accept a press or a release; legal range ≥ 1.
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  reset. One clock domain; reset is synchronous and active-high.
- COL  in  3  column sense, active-high. Bit 0 = left column, bit 2 = right column. Already synchronized by the pin wrapper.
- KEY_ACK  in  1  one-cycle acknowledge from the CPU; clears KEY_VALID and OVERRUN.
- ROW  out  4  one-hot row drive, active-high. Bit 0 = top row.
- KEY  out  4  last accepted key code.
- KEY_VALID  out  1  KEY holds an unacknowledged key.
- INTR  out  1  one-cycle pulse for each accepted key.
- OVERRUN  out  1  sticky flag: a key was accepted while KEY_VALID was already 1.

## Operation
- Key codes by row r and col c:
  - r0 = 1, 2, 3
  - r1 = 4, 5, 6
  - r2 = 7, 8, 9
  - r3 = 0xA (*), 0x0, 0xB (#)
- If several COL bits are high, the lowest bit index wins.
- Tick divider:
  - counts 0 … SCAN_DIV-1 and wraps.
  - `tick` is high in the cycle where count = SCAN_DIV-1.
  - All sample-based updates happen on the edge that ends a tick cycle.
- FSM states: SCAN, DEB_PRESS, HELD.
- SCAN, on each tick:
  - COL = 0: advance row index (3 wraps to 0).
  - COL ≠ 0: capture the candidate code, set match count = 1, freeze the row.
    - If DEBOUNCE_TICKS = 1, accept immediately and go to HELD.
    - Otherwise go to DEB_PRESS.
- DEB_PRESS (row frozen), on each tick:
  - Sampled code equals candidate: increment match count. When it reaches DEBOUNCE_TICKS, accept and go to HELD.
  - COL = 0 or a different code: go to SCAN and advance the row. The next scan starts on the following row.
- HELD (row frozen; release count starts at 0 on entry), on each tick:
  - COL = 0: increment release count. When it reaches DEBOUNCE_TICKS, go to SCAN and advance the row.
  - COL ≠ 0: reset release count to 0.
  - Held keys never re-trigger (no auto-repeat).
  - A second key pressed in another row is not seen until release completes.
- Accept, on a single edge:
  - KEY ← candidate.
  - KEY_VALID ← 1.
  - INTR ← 1 for exactly one CLK cycle.
  - OVERRUN ← 1 if KEY_VALID was 1 and KEY_ACK is not high in that cycle.
- KEY_ACK, when high in a cycle with no accept: KEY_VALID ← 0 and OVERRUN ← 0. KEY is unchanged.
- KEY_ACK and accept in the same cycle:
  - KEY ← new code, KEY_VALID stays 1, OVERRUN ← 0.
  - The old key counts as consumed.
- KEY_ACK while KEY_VALID = 0 has no effect.
- Widths: divider counter is clog2(SCAN_DIV) bits. Match and release counters are clog2(DEBOUNCE_TICKS+1) bits and saturate at DEBOUNCE_TICKS.

## Timing
- Reset values:
  - ROW = 4'b0001, KEY = 0, KEY_VALID = 0, INTR = 0, OVERRUN = 0.
  - State = SCAN, row index = 0, all counters = 0.
  - The first tick occurs SCAN_DIV cycles after reset deasserts.
- Reset mid-operation, including DEB_PRESS or HELD, returns to the reset state on the next edge.
  - A pending KEY_VALID is lost.
  - A key still held after reset is re-detected and re-accepted. This is intentional.
- ROW changes only on tick edges. Each row is driven for SCAN_DIV cycles before it is sampled.
- Press latency: the first detecting tick is t0. Accept occurs on the edge of tick t0 + (DEBOUNCE_TICKS-1). KEY, KEY_VALID and INTR are visible in the following cycle.
- Release: after DEBOUNCE_TICKS consecutive zero samples, ROW advances on that same edge.
- INTR is never high on two consecutive cycles. There is at most one INTR per press/release pair.

## Test plan
Simulation uses SCAN_DIV = 4, DEBOUNCE_TICKS = 3.
- Reset, no keys, 40 cycles:
  - ROW cycles 0001 → 0010 → 0100 → 1000 → 0001, changing every 4 cycles.
  - INTR and KEY_VALID stay 0.
- Press r1c2 stably, then release for 3 ticks:
  - KEY = 6, KEY_VALID = 1, one INTR pulse on the 3rd matching tick.
  - ROW is frozen at 0010 until 3 zero ticks, then 0100.
- Bounce: r0c0 is high for 2 ticks, low for 1, then stable:
  - No accept on the first burst; the scan resumes.
  - Exactly one accept later, with KEY = 1.
- r3c1, then r3c2, each with a full release, no KEY_ACK:
  - KEY = 0 then KEY = 0xB.
  - OVERRUN = 1 after the second accept.
  - KEY_ACK then clears KEY_VALID and OVERRUN.
- KEY_ACK asserted on the exact cycle of the second accept:
  - KEY_VALID stays 1, OVERRUN = 0, KEY holds the new code.
- RST pulsed during HELD with r2c0 still pressed:
  - All outputs return to reset values.
  - After re-scan, KEY = 7 is accepted again with one INTR.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad controller signal bundle: column sense and CPU acknowledge in,
// row drive and key/interrupt status out.
interface keypad_scan_ctrl_if;
  logic [2:0] col;
  logic       key_ack;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       intr;
  logic       overrun;

  modport master (
    output col, key_ack,
    input  row, key, key_valid, intr, overrun
  );

  modport slave (
    input  col, key_ack,
    output row, key, key_valid, intr, overrun
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: tick-enabled row rotation, press/release debounce,
// key holding register with one-cycle interrupt, valid and overrun flags.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 20000,
  parameter int unsigned DEBOUNCE_TICKS = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  keypad_scan_ctrl_if.slave  bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             intr_q, intr_d;
  logic             ovr_q, ovr_d;

  logic             tick_c;
  logic             col_any_c;
  logic [1:0]       col_idx_c;
  logic [3:0]       code_c;
  logic             match_hit_c;
  logic [CNT_W-1:0] match_inc_c;
  logic [CNT_W-1:0] rel_inc_c;
  logic             capture_c;
  logic             accept_c;
  logic             advance_c;

  assign tick_c    = (div_q == DIV_LAST);
  assign col_any_c = |bus.col;
  assign col_idx_c = bus.col[0] ? 2'd0 : (bus.col[1] ? 2'd1 : 2'd2);

  // Code of the key at the driven row and the lowest active column
  always_comb begin
    code_c = 4'h0;
    case (row_idx_q)
      2'd0: code_c = 4'(col_idx_c) + 4'd1;
      2'd1: code_c = 4'(col_idx_c) + 4'd4;
      2'd2: code_c = 4'(col_idx_c) + 4'd7;
      default: begin
        case (col_idx_c)
          2'd0:    code_c = 4'hA;
          2'd1:    code_c = 4'h0;
          default: code_c = 4'hB;
        endcase
      end
    endcase
  end

  assign match_hit_c = col_any_c && (code_c == cand_q);
  assign match_inc_c = (match_q == DEB_MAX) ? match_q : match_q + CNT_ONE;
  assign rel_inc_c   = (rel_q == DEB_MAX) ? rel_q : rel_q + CNT_ONE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN: begin
        if (tick_c && col_any_c) begin
          state_d = (DEB_MAX == CNT_ONE) ? ST_HELD : ST_DEB_PRESS;
        end
      end
      ST_DEB_PRESS: begin
        if (tick_c) begin
          if (!match_hit_c)                state_d = ST_SCAN;
          else if (match_inc_c == DEB_MAX) state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (tick_c && !col_any_c && (rel_inc_c == DEB_MAX)) state_d = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Per-state control strobes and debounce counter updates
  always_comb begin
    capture_c = 1'b0;
    accept_c  = 1'b0;
    advance_c = 1'b0;
    match_d   = match_q;
    rel_d     = rel_q;
    case (state_q)
      ST_SCAN: begin
        if (tick_c) begin
          if (col_any_c) begin
            capture_c = 1'b1;
            match_d   = CNT_ONE;
            rel_d     = '0;
            accept_c  = (DEB_MAX == CNT_ONE);
          end else begin
            advance_c = 1'b1;
          end
        end
      end
      ST_DEB_PRESS: begin
        if (tick_c) begin
          if (match_hit_c) begin
            match_d  = match_inc_c;
            rel_d    = '0;
            accept_c = (match_inc_c == DEB_MAX);
          end else begin
            match_d   = '0;
            advance_c = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (tick_c) begin
          if (col_any_c) begin
            rel_d = '0;
          end else begin
            rel_d     = rel_inc_c;
            advance_c = (rel_inc_c == DEB_MAX);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath next state; an accept coinciding with an ack consumes the old key
  always_comb begin
    div_d     = tick_c ? '0 : div_q + DIV_W'(1);
    row_idx_d = advance_c ? row_idx_q + 2'd1 : row_idx_q;
    row_d     = advance_c ? {row_q[2:0], row_q[3]} : row_q;
    cand_d    = capture_c ? code_c : cand_q;
    key_d     = key_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    intr_d    = accept_c;
    if (accept_c) begin
      key_d   = code_c;
      valid_d = 1'b1;
      ovr_d   = bus.key_ack ? 1'b0 : (ovr_q | valid_q);
    end else if (bus.key_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q     <= '0;
      row_idx_q <= 2'd0;
      row_q     <= 4'b0001;
      cand_q    <= 4'h0;
      match_q   <= '0;
      rel_q     <= '0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      intr_q    <= intr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.row       = row_q;
  assign bus.key       = key_q;
  assign bus.key_valid = valid_q;
  assign bus.intr      = intr_q;
  assign bus.overrun   = ovr_q;

endmodule
